// File: rtl/mem_access_unit.sv
// mem_access_unit: fetch/load/store sequencer for the unified MIPS memory; translates byte addresses to word indices.
// Optional MEM_ACCESS_STATS_EN adds saturating per-pulse counters readable through stat_sel/stat_count.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int TEXT_DEPTH = 37,
  parameter int DATA_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  store_done,
  output logic                  addr_error,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  input  logic [1:0]            stat_sel,
  output logic [15:0]           stat_count
`endif
);
  typedef enum logic [1:0] {IDLE, CHECK, ACCESS} state_t;
  state_t state, state_n;
  logic is_ls, is_st, legal, acc;
  logic [DATA_WIDTH-1:0] addr, wdata, base, w, xlat;
  always_comb begin
    base = is_ls ? DATA_BASE : TEXT_BASE;
    w = (addr - base) >> 2;
    legal = addr[1:0] == 2'b00 && addr >= base &&
            w < (is_ls ? DATA_WIDTH'(DATA_DEPTH) : DATA_WIDTH'(TEXT_DEPTH));
    xlat = is_ls ? w : (32'h0040_0000 | w);
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && (ls_req || fetch_req)) state_n = CHECK;
    else if (state == CHECK) state_n = legal ? ACCESS : IDLE;
    else if (state == ACCESS) state_n = IDLE;
    ready = state == IDLE;
    acc = state == ACCESS && !reset;
    mem_addr = acc ? xlat : '0;
    mem_wdata = acc ? wdata : '0;
    mem_we = acc && is_st;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      is_ls <= 1'b0;
      is_st <= 1'b0;
      addr <= '0;
      wdata <= '0;
      instr <= '0;
      load_data <= '0;
      instr_valid <= 1'b0;
      load_valid <= 1'b0;
      store_done <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      state <= state_n;
      instr_valid <= state == ACCESS && !is_ls;
      load_valid <= state == ACCESS && is_ls && !is_st;
      store_done <= state == ACCESS && is_st;
      addr_error <= state == CHECK && !legal;
      if (state == IDLE && (ls_req || fetch_req)) begin
        is_ls <= ls_req;
        is_st <= ls_req && ls_we;
        addr <= ls_req ? ls_addr : pc;
        wdata <= ls_wdata;
      end
      if (state == ACCESS && !is_ls) instr <= mem_rdata;
      if (state == ACCESS && is_ls && !is_st) load_data <= mem_rdata;
    end
  end
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] cnt [4];
  logic [3:0] pulse;
  assign pulse = {addr_error, store_done, load_valid, instr_valid};
  assign stat_count = cnt[stat_sel];
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (reset) cnt[i] <= '0;
      else if (pulse[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural unified memory.
module tb_mem_access_unit;
  logic clk = 0, reset = 1, fetch_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] pc = 0, ls_addr = 0, ls_wdata = 0;
  logic ready, instr_valid, load_valid, store_done, addr_error, mem_we;
  logic [31:0] instr, load_data, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:127];
`ifdef MEM_ACCESS_STATS_EN
  logic [1:0] stat_sel = 0;
  logic [15:0] stat_count;
`endif
  mem_access_unit dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ready(ready), .instr(instr), .instr_valid(instr_valid),
    .load_data(load_data), .load_valid(load_valid), .store_done(store_done), .addr_error(addr_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef MEM_ACCESS_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );
  always #5 clk = ~clk;
  // Text words live at 64+w, data words at w.
  assign mem_rdata = mem[{mem_addr[22], mem_addr[5:0]}];
  always @(posedge clk) if (mem_we) mem[{mem_addr[22], mem_addr[5:0]}] <= mem_wdata;
  typedef struct {logic [1:0] kind; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, we_cnt = 0;
  int ex_cnt [4];
  logic [31:0] we_addr = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] kind_of(input logic [3:0] p);
    return p[0] ? 0 : p[1] ? 1 : p[2] ? 2 : 3;
  endfunction
  task automatic expect_pulse(input logic [1:0] k, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
    ex_cnt[k]++;
  endtask
  always @(negedge clk) begin
    logic [3:0] p;
    exp_t e;
    if (!reset) begin
      p = {addr_error, store_done, load_valid, instr_valid};
      if (p != 0) begin
        check("onehot", $countones(p), 1);
        if (sb.size() == 0) check("unexpected_pulse", {28'd0, p}, 0);
        else begin
          e = sb.pop_front();
          check("kind", kind_of(p), {30'd0, e.kind});
          if (e.kind < 2) check("data", e.kind == 0 ? instr : load_data, e.data);
        end
      end
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
      end
    end
  end
  task automatic do_req(input string tag, input bit ls, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] ek, input logic [31:0] ed,
                        input logic [31:0] emaddr);
    int n, lat;
    logic [31:0] maddr;
    expect_pulse(ek, ed);
    @(negedge clk);
    if (ls) begin
      ls_req = 1; ls_we = we; ls_addr = a; ls_wdata = wd;
    end else begin
      fetch_req = 1; pc = a;
    end
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    maddr = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) maddr = mem_addr;
    end while (!(instr_valid | load_valid | store_done | addr_error) && lat < 10);
    check({tag, "_lat"}, lat, ek == 3 ? 2 : 3);
    if (ek != 3) check({tag, "_maddr"}, maddr, emaddr);
    fetch_req = 0;
    ls_req = 0;
  endtask
  initial begin
    int w0, lat;
    for (int i = 0; i < 128; i++) mem[i] = 0;
    mem[66] = 32'h2008_0005;
    mem[64] = 32'h1234_5678;
    mem[100] = 32'hABCD_0024;
    mem[31] = 32'hCAFE_0031;
    mem[2] = 32'h1111_1111;
    for (int i = 0; i < 4; i++) ex_cnt[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_instr", instr, 0);
    check("rst_load", load_data, 0);
    check("rst_ready", {31'd0, ready}, 1);
    check("rst_we", {31'd0, mem_we}, 0);
    check("rst_maddr", mem_addr, 0);
    reset = 0;
    do_req("fetch", 0, 0, 32'h0040_0008, 0, 0, 32'h2008_0005, 32'h0040_0002);
    w0 = we_cnt;
    do_req("store", 1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 2, 0, 32'h1);
    check("store_we_cycles", we_cnt - w0, 1);
    check("store_we_addr", we_addr, 1);
    do_req("load", 1, 0, 32'h1001_0004, 0, 1, 32'hDEAD_BEEF, 32'h1);
    do_req("load_last", 1, 0, 32'h1001_007C, 0, 1, 32'hCAFE_0031, 32'd31);
    do_req("fetch_last", 0, 0, 32'h0040_0090, 0, 0, 32'hABCD_0024, 32'h0040_0024);
    expect_pulse(1, 32'hDEAD_BEEF);
    expect_pulse(0, 32'h1234_5678);
    @(negedge clk);
    fetch_req = 1; pc = 32'h0040_0000;
    ls_req = 1; ls_we = 0; ls_addr = 32'h1001_0004;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!load_valid && lat < 10);
    check("arb_load_lat", lat, 3);
    ls_req = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!instr_valid && lat < 10);
    check("arb_fetch_lat", lat, 3);
    fetch_req = 0;
    w0 = we_cnt;
    do_req("err_misalign", 0, 0, 32'h0040_0002, 0, 3, 0, 0);
    do_req("err_range", 1, 1, 32'h1001_0080, 32'h5, 3, 0, 0);
    do_req("err_below", 1, 0, 32'h0000_0000, 0, 3, 0, 0);
    do_req("err_text_end", 0, 0, 32'h0040_0094, 0, 3, 0, 0);
    check("err_no_we", we_cnt - w0, 0);
    @(negedge clk);
    ls_req = 1; ls_we = 1; ls_addr = 32'h1001_0008; ls_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    ls_req = 0;
    @(negedge clk);
    reset = 1;
    #1 check("abort_we", {31'd0, mem_we}, 0);
    @(negedge clk);
    check("abort_mem", mem[2], 32'h1111_1111);
    check("abort_ready", {31'd0, ready}, 1);
    check("abort_instr", instr, 0);
    check("abort_load", load_data, 0);
    check("abort_pulses", {28'd0, addr_error, store_done, load_valid, instr_valid}, 0);
    check("abort_maddr", mem_addr, 0);
    check("abort_wdata", mem_wdata, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) ex_cnt[i] = 0;
    do_req("s_fetch0", 0, 0, 32'h0040_0008, 0, 0, 32'h2008_0005, 32'h0040_0002);
    do_req("s_fetch1", 0, 0, 32'h0040_0000, 0, 0, 32'h1234_5678, 32'h0040_0000);
    do_req("s_store", 1, 1, 32'h1001_0010, 32'h0000_0777, 2, 0, 32'h4);
    do_req("s_load", 1, 0, 32'h1001_0010, 0, 1, 32'h0000_0777, 32'h4);
    do_req("s_err", 1, 0, 32'h1001_0001, 0, 3, 0, 0);
    repeat (3) @(negedge clk);
`ifdef MEM_ACCESS_STATS_EN
    for (int i = 0; i < 4; i++) begin
      stat_sel = 2'(i);
      #1 check("stat_count", {16'd0, stat_count}, ex_cnt[i]);
    end
`endif
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
